// File: rtl/calculator_core.sv
// Operand-entry and arithmetic engine for the calculator display path.
// Captures A/B from switches, then runs add/sub/mul or an iterative restoring divide.
module calculator_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             load,
  input  logic             go,
  input  logic             clr,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             flag,
  output logic             busy,
  output logic [2:0]       state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    READY  = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] quot, rem;
  logic [CNT_W-1:0] cnt;
  logic             busy_d;
  logic             soft_rst;

  logic [WIDTH:0]   rem_shift, diff;
  logic             take;
  logic [WIDTH-1:0] quot_next, rem_next;

  // Single-cycle ops return {flag, result}; flag is carry, borrow or high-half nonzero.
  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [1:0]       sel);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    sum  = '0;
    prod = '0;
    case (sel)
      2'b00: sum = {1'b0, a} + {1'b0, b};
      2'b01: sum = {1'b0, a} - {1'b0, b};
      2'b10: begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        sum  = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
      end
      default: sum = '0;
    endcase
    return sum;
  endfunction

  assign soft_rst = rst | clr;
  assign state    = cur;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem, quot[WIDTH-1]};
    diff      = rem_shift - {1'b0, B};
    take      = ~diff[WIDTH];
    rem_next  = take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (soft_rst) cur <= LOAD_A;
    else          cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      LOAD_A: if (load) nxt = LOAD_B;
      LOAD_B: if (load) nxt = READY;
      READY:  if (go)   nxt = EXEC;
      EXEC:   if (op_r != 2'b11 || B == '0 || cnt == CNT_W'(1)) nxt = DONE;
      DONE:   if (load) nxt = LOAD_B;
      default: nxt = LOAD_A;
    endcase
  end

  always_comb begin
    busy_d = (nxt == EXEC);
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      A    <= '0;
      B    <= '0;
      C    <= '0;
      flag <= 1'b0;
      busy <= 1'b0;
      op_r <= 2'b00;
      quot <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_d;
      case (cur)
        LOAD_A: if (load) A <= sw;
        LOAD_B: if (load) B <= sw;
        READY: if (go) begin
          op_r <= op;
          quot <= A;
          rem  <= '0;
          cnt  <= CNT_W'(WIDTH);
        end
        EXEC: begin
          if (op_r != 2'b11) begin
            {flag, C} <= alu(A, B, op_r);
          end else if (B == '0) begin
            C    <= '1;
            flag <= 1'b1;
          end else begin
            quot <= quot_next;
            rem  <= rem_next;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              C    <= quot_next;
              flag <= 1'b0;
            end
          end
        end
        DONE: if (load) begin
          A    <= sw;
          C    <= '0;
          flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
